slide_debounce: RTL

Synchronises and debounces the DE10-Lite slide switches before they reach the slide PIO input (`slide_pio_external_export`) of the `core` Qsys system. Each switch bit passes through a multi-flop synchroniser and a per-bit stability counter. The bit's registered level changes only after it has held a new value for a programmable number of cycles. Per-bit change pulses are produced for fabric logic that needs event detection alongside the PIO.

---
 rtl/slide_debounce_if.sv | 20 ++
 rtl/slide_debounce.sv | 85 ++++++++
 2 files changed

// File: rtl/slide_debounce_if.sv
// Switch-side signal bundle for slide_debounce: raw pins in, debounced level and edge pulses out.
interface slide_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_any_change;

  modport master (
    output sw_raw,
    input  sw_stable, sw_rise, sw_fall, sw_any_change
  );

  modport slave (
    input  sw_raw,
    output sw_stable, sw_rise, sw_fall, sw_any_change
  );
endinterface

// File: rtl/slide_debounce.sv
// Per-bit synchroniser + stability counter for the DE10-Lite slide switches.
// Define SLIDE_DEBOUNCE_EDGE_EN to generate the registered rise/fall/any-change pulses.
module slide_debounce #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  slide_debounce_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0]          r_cnt;
  logic [WIDTH-1:0]                  r_stable;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_accept;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= bus.sw_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // A bit is accepted on the edge where its counter sits at the limit and it still differs.
  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_accept[i] = (w_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((w_sync[i] == r_stable[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
      r_stable <= (r_stable & ~w_accept) | (w_sync & w_accept);
    end
  end

`ifdef SLIDE_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      r_rise <= w_accept & w_sync;
      r_fall <= w_accept & ~w_sync;
      r_any  <= |w_accept;
    end
  end

  assign bus.sw_rise       = r_rise;
  assign bus.sw_fall       = r_fall;
  assign bus.sw_any_change = r_any;
`else
  assign bus.sw_rise       = '0;
  assign bus.sw_fall       = '0;
  assign bus.sw_any_change = 1'b0;
`endif

  assign bus.sw_stable = r_stable;
endmodule
